// File: rtl/buff_pkg.sv
// Shared definitions for the chunk serializer / deserializer pair: chunk count helper and FSM states.
package buff_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } buff_state_e;

    function automatic int chunk_count(input int data_bits, input int bits);
        return data_bits / bits;
    endfunction

endpackage

// File: rtl/debuff_shreg.sv
// DATA_BITS-wide assembly register: load chunk 0 into the LSBs, then shift left by BITS per chunk.
module debuff_shreg #(
    parameter int DATA_BITS = 264,
    parameter int BITS      = 8
) (
    input  logic                 clk,
    input  logic                 clr_i,
    input  logic                 load_i,
    input  logic                 shift_i,
    input  logic [BITS-1:0]      b_i,
    output logic [DATA_BITS-1:0] shifted_o
);

    logic [DATA_BITS-1:0] shreg_q;
    logic [DATA_BITS-1:0] shreg_d;

    // shifted_o is the value the register takes on a shift; the FSM also publishes it as the word.
    generate
        if (DATA_BITS > BITS) begin : g_wide
            assign shifted_o = {shreg_q[DATA_BITS-BITS-1:0], b_i};
        end else begin : g_single
            assign shifted_o = DATA_BITS'(b_i);
        end
    endgenerate

    always_comb begin
        shreg_d = shreg_q;
        if (load_i) begin
            shreg_d = DATA_BITS'(b_i);
        end else if (shift_i) begin
            shreg_d = shifted_o;
        end
    end

    always_ff @(posedge clk) begin
        if (clr_i) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

endmodule

// File: rtl/debuff.sv
// Chunk deserializer: rebuilds a DATA_BITS word from MSB-first BITS-wide chunks, one per clock.
// Optional overrun reporting (err pulse + 16-bit saturating counter) under DEBUFF_OVERRUN_EN.
module debuff
    import buff_pkg::*;
#(
    parameter int DATA_BITS = 264,
    parameter int BITS      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_in,
    input  logic [BITS-1:0]      b_in,
    output logic                 done,
    output logic [DATA_BITS-1:0] word_out,
    output logic                 busy,
    output logic                 err
);

    localparam int COUNT = chunk_count(DATA_BITS, BITS);
    localparam int CW    = $clog2(COUNT + 1);

    generate
        if ((DATA_BITS % BITS) != 0 || COUNT < 1) begin : g_bad_ratio
            $error("debuff: DATA_BITS must be a non-zero multiple of BITS");
        end
    endgenerate

    buff_state_e          state_q;
    logic [CW-1:0]        cnt_q;
    logic [DATA_BITS-1:0] word_q;
    logic                 done_q;
    logic [DATA_BITS-1:0] shifted;
    logic                 shift_en;
    logic                 restart;

    // Any start_in begins a fresh frame, whether idle or mid-frame.
    assign shift_en = (state_q == COLLECT) && !start_in;
    assign restart  = (state_q == COLLECT) && start_in;

    debuff_shreg #(
        .DATA_BITS (DATA_BITS),
        .BITS      (BITS)
    ) u_shreg (
        .clk       (clk),
        .clr_i     (rst),
        .load_i    (start_in),
        .shift_i   (shift_en),
        .b_i       (b_in),
        .shifted_o (shifted)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            word_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_in) begin
                        if (COUNT == 1) begin
                            word_q <= DATA_BITS'(b_in);
                            done_q <= 1'b1;
                            cnt_q  <= '0;
                        end else begin
                            cnt_q   <= CW'(1);
                            state_q <= COLLECT;
                        end
                    end
                end
                COLLECT: begin
                    if (start_in) begin
                        cnt_q <= CW'(1);
                    end else if (cnt_q == CW'(COUNT - 1)) begin
                        word_q  <= shifted;
                        done_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign done     = done_q;
    assign word_out = word_q;
    assign busy     = (state_q == COLLECT);

`ifdef DEBUFF_OVERRUN_EN
    logic        err_q;
    logic [15:0] ovr_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q     <= 1'b0;
            ovr_cnt_q <= '0;
        end else begin
            err_q <= restart;
            if (restart && (ovr_cnt_q != 16'hFFFF)) begin
                ovr_cnt_q <= ovr_cnt_q + 16'd1;
            end
        end
    end

    assign err = err_q;
`else
    logic unused_restart;
    assign unused_restart = restart;
    assign err = 1'b0;
`endif

endmodule
